instruction_decode: RTL

- ID stage of the 5-stage MIPS pipeline, directly downstream of instruction fetch.
- Contains the IF/ID pipeline register, a 32x32 register file, the main control decoder and immediate generation.
- Contains load-use hazard detection and the ID/EX pipeline register.
- Consumes the fetched PC and instruction; feeds the execute stage; drives a stall back to fetch.

---
 rtl/instruction_decode.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/instruction_decode.sv
// Instruction decode stage of the 5-stage MIPS pipeline: IF/ID register,
// register file with write-through bypass, main decoder, immediate
// generation, load-use hazard detection and the ID/EX register.
module instruction_decode #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] if_pc,
  input  logic [31:0]           if_instruction,
  input  logic                  flush,
  input  logic                  wb_reg_write,
  input  logic [4:0]            wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  stall,
  output logic                  ex_valid,
  output logic [ADDR_WIDTH-1:0] ex_pc_plus4,
  output logic [DATA_WIDTH-1:0] ex_rs_data,
  output logic [DATA_WIDTH-1:0] ex_rt_data,
  output logic [DATA_WIDTH-1:0] ex_imm,
  output logic [4:0]            ex_rs,
  output logic [4:0]            ex_rt,
  output logic [4:0]            ex_dest,
  output logic [4:0]            ex_shamt,
  output logic [3:0]            ex_alu_op,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg,
  output logic                  ex_alu_src,
  output logic                  ex_branch_eq,
  output logic                  ex_branch_ne,
  output logic                  ex_jump,
  output logic                  ex_jump_reg,
  output logic                  ex_link,
  output logic [ADDR_WIDTH-1:0] ex_jump_target,
  output logic                  ex_illegal
);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR  = 6'h08, FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR  = 6'h25, FN_SLT = 6'h2A;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_LUI = 4'd7;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] rs_data;
    logic [DATA_WIDTH-1:0] rt_data;
    logic [DATA_WIDTH-1:0] imm;
    logic [4:0]            rs;
    logic [4:0]            rt;
    logic [4:0]            dest;
    logic [4:0]            shamt;
    logic [3:0]            alu_op;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  alu_src;
    logic                  branch_eq;
    logic                  branch_ne;
    logic                  jump;
    logic                  jump_reg;
    logic                  link;
    logic [ADDR_WIDTH-1:0] jump_target;
    logic                  illegal;
  } idex_t;

  function automatic logic [DATA_WIDTH-1:0] sign_extend16(input logic signed [15:0] v);
    logic signed [DATA_WIDTH-1:0] ext;
    ext = DATA_WIDTH'(v);
    return ext;
  endfunction

  logic                  vld_p0;
  logic [ADDR_WIDTH-1:0] pc_p0;
  logic [31:0]           instr_p0;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  idex_t                 idex_p1, idex_nx;

  logic [5:0]            opcode, funct;
  logic [4:0]            rs, rt, rd;
  logic [15:0]           imm16;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] rs_data, rt_data, d_imm;
  logic [3:0]            d_alu_op;
  logic [4:0]            d_dest;
  logic d_reg_write, d_mem_read, d_mem_write, d_mem_to_reg, d_alu_src;
  logic d_branch_eq, d_branch_ne, d_jump, d_jump_reg, d_link, d_illegal, d_uses_rt;
  logic bubble;

  assign opcode   = instr_p0[31:26];
  assign rs       = instr_p0[25:21];
  assign rt       = instr_p0[20:16];
  assign rd       = instr_p0[15:11];
  assign funct    = instr_p0[5:0];
  assign imm16    = instr_p0[15:0];
  assign pc_plus4 = pc_p0 + ADDR_WIDTH'(4);

  // IF/ID boundary: flush squashes, stall holds, otherwise capture fetch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0   <= 1'b0;
      pc_p0    <= '0;
      instr_p0 <= '0;
    end else if (flush) begin
      vld_p0   <= 1'b0;
      instr_p0 <= '0;
    end else if (!stall) begin
      vld_p0   <= 1'b1;
      pc_p0    <= if_pc;
      instr_p0 <= if_instruction;
    end
  end

  // Register file write port; r0 is never written
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_reg_write && wb_rd != 5'd0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Read ports see a same-cycle writeback so WB->ID needs no extra forwarding
  assign rs_data = (rs == 5'd0) ? '0 : (wb_reg_write && wb_rd == rs) ? wb_data : regs[rs];
  assign rt_data = (rt == 5'd0) ? '0 : (wb_reg_write && wb_rd == rt) ? wb_data : regs[rt];

  // Main decoder: control bits, destination and immediate form per opcode/funct
  always_comb begin
    d_alu_op     = ALU_ADD;
    d_reg_write  = 1'b0;
    d_mem_read   = 1'b0;
    d_mem_write  = 1'b0;
    d_mem_to_reg = 1'b0;
    d_alu_src    = 1'b0;
    d_branch_eq  = 1'b0;
    d_branch_ne  = 1'b0;
    d_jump       = 1'b0;
    d_jump_reg   = 1'b0;
    d_link       = 1'b0;
    d_illegal    = 1'b0;
    d_uses_rt    = 1'b0;
    d_dest       = rt;
    d_imm        = sign_extend16(imm16);
    case (opcode)
      OP_RTYPE: begin
        d_dest      = rd;
        d_uses_rt   = 1'b1;
        d_reg_write = 1'b1;
        case (funct)
          FN_ADD:  d_alu_op = ALU_ADD;
          FN_SUB:  d_alu_op = ALU_SUB;
          FN_AND:  d_alu_op = ALU_AND;
          FN_OR:   d_alu_op = ALU_OR;
          FN_SLT:  d_alu_op = ALU_SLT;
          FN_SLL:  d_alu_op = ALU_SLL;
          FN_SRL:  d_alu_op = ALU_SRL;
          FN_JR: begin
            d_jump_reg  = 1'b1;
            d_reg_write = 1'b0;
          end
          default: begin
            d_illegal   = 1'b1;
            d_reg_write = 1'b0;
          end
        endcase
      end
      OP_LW: begin
        d_alu_src    = 1'b1;
        d_mem_read   = 1'b1;
        d_mem_to_reg = 1'b1;
        d_reg_write  = 1'b1;
      end
      OP_SW: begin
        d_alu_src   = 1'b1;
        d_mem_write = 1'b1;
        d_uses_rt   = 1'b1;
      end
      OP_ADDI: begin d_alu_src = 1'b1; d_reg_write = 1'b1; end
      OP_SLTI: begin d_alu_src = 1'b1; d_reg_write = 1'b1; d_alu_op = ALU_SLT; end
      OP_ANDI: begin
        d_alu_src = 1'b1; d_reg_write = 1'b1; d_alu_op = ALU_AND;
        d_imm     = {{(DATA_WIDTH-16){1'b0}}, imm16};
      end
      OP_ORI: begin
        d_alu_src = 1'b1; d_reg_write = 1'b1; d_alu_op = ALU_OR;
        d_imm     = {{(DATA_WIDTH-16){1'b0}}, imm16};
      end
      OP_LUI: begin
        d_alu_src = 1'b1; d_reg_write = 1'b1; d_alu_op = ALU_LUI;
        d_imm     = {imm16, {(DATA_WIDTH-16){1'b0}}};
      end
      OP_BEQ: begin d_alu_op = ALU_SUB; d_branch_eq = 1'b1; d_uses_rt = 1'b1; end
      OP_BNE: begin d_alu_op = ALU_SUB; d_branch_ne = 1'b1; d_uses_rt = 1'b1; end
      OP_J:   begin d_jump = 1'b1; d_dest = 5'd0; end
      OP_JAL: begin d_jump = 1'b1; d_link = 1'b1; d_reg_write = 1'b1; d_dest = 5'd31; end
      default: d_illegal = 1'b1;
    endcase
    if (d_illegal) d_dest = 5'd0;
  end

  // A load in EX whose destination is a source of the instruction in ID must wait a cycle
  assign stall = ex_valid && ex_mem_read && (ex_dest != 5'd0) && vld_p0 &&
                 ((ex_dest == rs) || (d_uses_rt && (ex_dest == rt)));

  assign bubble = flush || stall || !vld_p0;

  // Assemble the next ID/EX word; a bubble is an all-zero word
  always_comb begin
    idex_nx = '0;
    if (!bubble) begin
      idex_nx.valid       = 1'b1;
      idex_nx.pc_plus4    = pc_plus4;
      idex_nx.rs_data     = rs_data;
      idex_nx.rt_data     = rt_data;
      idex_nx.imm         = d_imm;
      idex_nx.rs          = rs;
      idex_nx.rt          = rt;
      idex_nx.dest        = d_dest;
      idex_nx.shamt       = instr_p0[10:6];
      idex_nx.alu_op      = d_alu_op;
      idex_nx.reg_write   = d_reg_write;
      idex_nx.mem_read    = d_mem_read;
      idex_nx.mem_write   = d_mem_write;
      idex_nx.mem_to_reg  = d_mem_to_reg;
      idex_nx.alu_src     = d_alu_src;
      idex_nx.branch_eq   = d_branch_eq;
      idex_nx.branch_ne   = d_branch_ne;
      idex_nx.jump        = d_jump;
      idex_nx.jump_reg    = d_jump_reg;
      idex_nx.link        = d_link;
      idex_nx.jump_target = {pc_plus4[ADDR_WIDTH-1:ADDR_WIDTH-4], instr_p0[25:0], 2'b00};
      idex_nx.illegal     = d_illegal;
    end
  end

  // ID/EX boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) idex_p1 <= '0;
    else       idex_p1 <= idex_nx;
  end

  assign ex_valid       = idex_p1.valid;
  assign ex_pc_plus4    = idex_p1.pc_plus4;
  assign ex_rs_data     = idex_p1.rs_data;
  assign ex_rt_data     = idex_p1.rt_data;
  assign ex_imm         = idex_p1.imm;
  assign ex_rs          = idex_p1.rs;
  assign ex_rt          = idex_p1.rt;
  assign ex_dest        = idex_p1.dest;
  assign ex_shamt       = idex_p1.shamt;
  assign ex_alu_op      = idex_p1.alu_op;
  assign ex_reg_write   = idex_p1.reg_write;
  assign ex_mem_read    = idex_p1.mem_read;
  assign ex_mem_write   = idex_p1.mem_write;
  assign ex_mem_to_reg  = idex_p1.mem_to_reg;
  assign ex_alu_src     = idex_p1.alu_src;
  assign ex_branch_eq   = idex_p1.branch_eq;
  assign ex_branch_ne   = idex_p1.branch_ne;
  assign ex_jump        = idex_p1.jump;
  assign ex_jump_reg    = idex_p1.jump_reg;
  assign ex_link        = idex_p1.link;
  assign ex_jump_target = idex_p1.jump_target;
  assign ex_illegal     = idex_p1.illegal;

endmodule
